// File: rtl/fft_out_reorder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_out_reorder_pkg
// Purpose  : Shared constants, lane word type and index helpers for the
//            parallel-4 FFT output reorder stage.
// Revision : 1.0 - initial release
// ============================================================================
package fft_out_reorder_pkg;

  // Samples delivered per clock by the FFT core
  localparam int LANES = 4;

  // Default real/imag width; one lane word holds a complex sample
  localparam int WORD_NBITS = 10;
  typedef logic [2*WORD_NBITS-1:0] word_t;

  // Reverse the low w bits of v (w up to 32)
  function automatic int unsigned bitrev(input int unsigned v, input int unsigned w);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(w)) r[i[4:0]] = v[5'(w - 1 - i)];
    end
    return r;
  endfunction

  // Bank that holds sample idx: low two index bits XOR top two index bits.
  // Both the bit-reversed write beat and the natural-order read beat then
  // touch four distinct banks.
  function automatic logic [1:0] bank_of(input int unsigned idx, input int unsigned log2n);
    logic [1:0] lo;
    logic [1:0] hi;
    lo = idx[1:0];
    hi = 2'(idx >> (log2n - 2));
    return lo ^ hi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_reorder_bank.sv
`default_nettype none
// ============================================================================
// Module   : fft_reorder_bank
// Purpose  : Simple dual-port RAM, one write port and one registered read
//            port. Storage is never cleared; only the read register resets.
// Revision : 1.0 - initial release
// ============================================================================
module fft_reorder_bank #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: storage has no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: one-cycle latency, register cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_out_reorder
// Purpose  : Takes 4 bit-reversed FFT bins per clock, stores each frame in a
//            ping-pong 4-bank buffer and streams it back in natural order.
// Revision : 1.0 - initial release
// ============================================================================
module fft_out_reorder
  import fft_out_reorder_pkg::*;
#(
  parameter int NBITS = 10,
  parameter int N     = 128,
  parameter int LOG2N = 7,
  parameter int BEATS = N / 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_enable,
  input  logic                 in_sof,
  input  logic [NBITS*2-1:0]   fftIn0_up,
  input  logic [NBITS*2-1:0]   fftIn0_down,
  input  logic [NBITS*2-1:0]   fftIn1_up,
  input  logic [NBITS*2-1:0]   fftIn1_down,
  output logic [NBITS*2-1:0]   fftOut0_up,
  output logic [NBITS*2-1:0]   fftOut0_down,
  output logic [NBITS*2-1:0]   fftOut1_up,
  output logic [NBITS*2-1:0]   fftOut1_down,
  output logic                 o_enable,
  output logic                 o_sof,
  output logic                 o_overrun
);

  localparam int W  = NBITS * 2;
  localparam int CW = LOG2N - 2;         // beat counter width
  localparam int AW = LOG2N - 1;         // bank address {half, row}
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [W-1:0]    in_lane    [LANES];
  logic [W-1:0]    bank_wdata [LANES];
  logic [AW-1:0]   bank_waddr [LANES];
  logic [W-1:0]    bank_rdata [LANES];
  logic [W-1:0]    out_lane   [LANES];
  logic [1:0]      lane_bank  [LANES];
  logic [CW-1:0]   lane_row   [LANES];

  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   wbeat;
  logic            whalf;
  logic            frame_done;

  logic [0:0]      state;
  logic [CW-1:0]   rcnt;
  logic            rhalf;
  logic            pending;
  logic            pend_half;
  logic            overrun;
  logic            rd_active;
  logic [AW-1:0]   rd_addr;
  logic [1:0]      rsel;

  assign in_lane[0] = fftIn0_up;
  assign in_lane[1] = fftIn0_down;
  assign in_lane[2] = fftIn1_up;
  assign in_lane[3] = fftIn1_down;

  // A start-of-frame beat is always beat 0, discarding any partial frame
  assign wbeat      = in_sof ? '0 : wcnt;
  assign frame_done = in_enable && (wbeat == LAST_BEAT);

  // Write counter and write half; the half flips only when a frame completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      whalf <= 1'b0;
    end else if (in_enable) begin
      if (frame_done) begin
        wcnt  <= '0;
        whalf <= ~whalf;
      end else begin
        wcnt  <= wbeat + 1'b1;
      end
    end
  end

  // Write crossbar: locate each lane's bin, then steer it to its bank
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int l = 0; l < LANES; l++) begin
      idx          = bitrev((32'(wbeat) << 2) | 32'(l), LOG2N);
      lane_bank[l] = bank_of(idx, LOG2N);
      lane_row[l]  = CW'(idx >> 2);
    end
    for (int b = 0; b < LANES; b++) begin
      bank_wdata[b] = '0;
      bank_waddr[b] = '0;
      for (int l = 0; l < LANES; l++) begin
        if (lane_bank[l] == 2'(b)) begin
          bank_wdata[b] = in_lane[l];
          bank_waddr[b] = {whalf, lane_row[l]};
        end
      end
    end
  end

  assign rd_active = (state == S_READ);
  // Natural-order beat c lives at row c in every bank
  assign rd_addr   = {rhalf, rcnt};

  // Read sequencer: IDLE/READ, one pending frame slot, sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rcnt      <= '0;
      rhalf     <= 1'b0;
      pending   <= 1'b0;
      pend_half <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_done) begin
            state <= S_READ;
            rcnt  <= '0;
            rhalf <= whalf;
          end
        end
        S_READ: begin
          if (frame_done && pending) overrun <= 1'b1;
          if (rcnt == LAST_BEAT) begin
            rcnt <= '0;
            if (pending) begin
              rhalf     <= pend_half;
              pending   <= frame_done;
              pend_half <= whalf;
            end else if (frame_done) begin
              rhalf <= whalf;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            rcnt <= rcnt + 1'b1;
            if (frame_done) begin
              pending   <= 1'b1;
              pend_half <= whalf;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output flags and read-crossbar select, aligned with RAM read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_enable <= 1'b0;
      o_sof    <= 1'b0;
      rsel     <= 2'b00;
    end else begin
      o_enable <= rd_active;
      o_sof    <= rd_active && (rcnt == '0);
      if (rd_active) rsel <= rcnt[CW-1:CW-2];
    end
  end

  generate
    for (genvar b = 0; b < LANES; b++) begin : g_bank
      fft_reorder_bank #(
        .WIDTH (W),
        .DEPTH (2 * BEATS),
        .AW    (AW)
      ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_enable),
        .wr_addr (bank_waddr[b]),
        .wr_data (bank_wdata[b]),
        .rd_en   (rd_active),
        .rd_addr (rd_addr),
        .rd_data (bank_rdata[b])
      );
    end
  endgenerate

  // Read crossbar: lane l of beat c sits in bank l XOR c[top two bits]
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      out_lane[l] = bank_rdata[2'(l) ^ rsel];
    end
  end

  assign fftOut0_up   = out_lane[0];
  assign fftOut0_down = out_lane[1];
  assign fftOut1_up   = out_lane[2];
  assign fftOut1_down = out_lane[3];
  assign o_overrun    = overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fft_out_reorder
// Purpose  : Self-checking bench for fft_out_reorder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_out_reorder;
  import fft_out_reorder_pkg::*;

  localparam int NBITS = 10;
  localparam int N     = 128;
  localparam int LOG2N = 7;
  localparam int BEATS = 32;
  localparam int W     = 2 * NBITS;

  typedef struct {
    logic                sof;
    logic [3:0][W-1:0]   d;
    int                  cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_enable = 1'b0;
  logic          in_sof = 1'b0;
  logic [W-1:0]  in_l [4];
  logic [W-1:0]  out0u, out0d, out1u, out1d;
  logic          o_enable, o_sof, o_overrun;

  int    cyc = 0;
  int    asserts = 0;
  int    fails = 0;
  beat_t got[$];
  beat_t exp_q[$];

  fft_out_reorder #(.NBITS(NBITS), .N(N), .LOG2N(LOG2N), .BEATS(BEATS)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_enable    (in_enable),
    .in_sof       (in_sof),
    .fftIn0_up    (in_l[0]),
    .fftIn0_down  (in_l[1]),
    .fftIn1_up    (in_l[2]),
    .fftIn1_down  (in_l[3]),
    .fftOut0_up   (out0u),
    .fftOut0_down (out0d),
    .fftOut1_up   (out1u),
    .fftOut1_down (out1d),
    .o_enable     (o_enable),
    .o_sof        (o_sof),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output beat with its cycle number
  always @(negedge clk) begin
    if (o_enable) begin
      beat_t b;
      b.sof = o_sof;
      b.d[0] = out0u; b.d[1] = out0d; b.d[2] = out1u; b.d[3] = out1d;
      b.cyc = cyc;
      got.push_back(b);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
    in_enable = 1'b0;
    in_sof    = 1'($urandom_range(0, 1));   // ignored while enable is low
    for (int l = 0; l < 4; l++) in_l[l] = W'($urandom);
  endtask

  task automatic drive_beat(input int c, input logic [W-1:0] tag, input logic sof);
    @(posedge clk); #1;
    in_enable = 1'b1;
    in_sof    = sof;
    for (int l = 0; l < 4; l++) in_l[l] = W'(bitrev(4 * c + l, LOG2N)) + tag;
  endtask

  task automatic push_frame(input logic [W-1:0] tag);
    beat_t e;
    for (int c = 0; c < BEATS; c++) begin
      e.sof = (c == 0);
      for (int l = 0; l < 4; l++) e.d[l] = W'(4 * c + l) + tag;
      e.cyc = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_frame(input logic [W-1:0] tag, input bit gaps, output int last_cyc);
    for (int c = 0; c < BEATS; c++) begin
      if (gaps) while ($urandom_range(0, 1) == 0) idle_cycle();
      drive_beat(c, tag, c == 0);
    end
    last_cyc = cyc;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 400 && got.size() < exp_q.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    asserts++; if (o_enable !== 1'b0) begin fails++; $display("FAIL reset_enable: got %b want 0", o_enable); end
    asserts++; if (o_sof !== 1'b0) begin fails++; $display("FAIL reset_sof: got %b want 0", o_sof); end
    asserts++; if (o_overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
    asserts++; if ({out0u, out0d, out1u, out1d} !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", {out0u, out0d, out1u, out1d}); end
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) idle_cycle();
    got.delete();
  endtask

  task automatic test_single_frame();
    beat_t e, g;
    int last, prev;
    push_frame('0);
    drive_frame('0, 1'b0, last);
    idle_cycle();
    wait_out();
    asserts++; if (got.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d want %0d", got.size(), exp_q.size()); end
    if (got.size() > 0) begin
      asserts++; if (got[0].cyc != last + 2) begin fails++; $display("FAIL single_latency: first out cycle %0d want %0d", got[0].cyc, last + 2); end
    end
    prev = 0;
    for (int i = 0; exp_q.size() > 0 && got.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got.pop_front();
      asserts++; if (g.sof !== e.sof) begin fails++; $display("FAIL single_sof beat %0d: got %b want %b", i, g.sof, e.sof); end
      for (int l = 0; l < 4; l++) begin
        asserts++; if (g.d[l] !== e.d[l]) begin fails++; $display("FAIL single_data beat %0d lane %0d: got %h want %h", i, l, g.d[l], e.d[l]); end
      end
      if (i > 0) begin
        asserts++; if (g.cyc != prev + 1) begin fails++; $display("FAIL single_gap beat %0d: cycle %0d want %0d", i, g.cyc, prev + 1); end
      end
      prev = g.cyc;
    end
    exp_q.delete(); got.delete();
  endtask

  task automatic test_back_to_back();
    beat_t e, g;
    int last, prev;
    for (int f = 1; f <= 3; f++) begin
      push_frame(W'(f * 'h100));
      drive_frame(W'(f * 'h100), 1'b0, last);
    end
    idle_cycle();
    wait_out();
    asserts++; if (got.size() != 3 * BEATS) begin fails++; $display("FAIL b2b_count: got %0d want %0d", got.size(), 3 * BEATS); end
    asserts++; if (o_overrun !== 1'b0) begin fails++; $display("FAIL b2b_overrun: got %b want 0", o_overrun); end
    prev = 0;
    for (int i = 0; exp_q.size() > 0 && got.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got.pop_front();
      asserts++; if (g.sof !== e.sof) begin fails++; $display("FAIL b2b_sof beat %0d: got %b want %b", i, g.sof, e.sof); end
      for (int l = 0; l < 4; l++) begin
        asserts++; if (g.d[l] !== e.d[l]) begin fails++; $display("FAIL b2b_data beat %0d lane %0d: got %h want %h", i, l, g.d[l], e.d[l]); end
      end
      if (i > 0) begin
        asserts++; if (g.cyc != prev + 1) begin fails++; $display("FAIL b2b_gap beat %0d: cycle %0d want %0d", i, g.cyc, prev + 1); end
      end
      prev = g.cyc;
    end
    exp_q.delete(); got.delete();
  endtask

  task automatic test_random_enable();
    beat_t e, g;
    int last, prev;
    for (int f = 0; f < 2; f++) begin
      push_frame(W'('h40 << f));
      drive_frame(W'('h40 << f), 1'b1, last);
    end
    idle_cycle();
    wait_out();
    asserts++; if (got.size() != 2 * BEATS) begin fails++; $display("FAIL rand_count: got %0d want %0d", got.size(), 2 * BEATS); end
    asserts++; if (o_overrun !== 1'b0) begin fails++; $display("FAIL rand_overrun: got %b want 0", o_overrun); end
    prev = 0;
    for (int i = 0; exp_q.size() > 0 && got.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got.pop_front();
      asserts++; if (g.sof !== e.sof) begin fails++; $display("FAIL rand_sof beat %0d: got %b want %b", i, g.sof, e.sof); end
      for (int l = 0; l < 4; l++) begin
        asserts++; if (g.d[l] !== e.d[l]) begin fails++; $display("FAIL rand_data beat %0d lane %0d: got %h want %h", i, l, g.d[l], e.d[l]); end
      end
      if (i % BEATS != 0) begin
        asserts++; if (g.cyc != prev + 1) begin fails++; $display("FAIL rand_burst beat %0d: cycle %0d want %0d", i, g.cyc, prev + 1); end
      end
      prev = g.cyc;
    end
    exp_q.delete(); got.delete();
  endtask

  task automatic test_sof_restart();
    beat_t e, g;
    int last;
    for (int c = 0; c < 17; c++) drive_beat(c, W'('h500), c == 0);
    push_frame(W'('h600));
    drive_frame(W'('h600), 1'b0, last);
    idle_cycle();
    wait_out();
    asserts++; if (got.size() != BEATS) begin fails++; $display("FAIL sof_count: got %0d want %0d", got.size(), BEATS); end
    for (int i = 0; exp_q.size() > 0 && got.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got.pop_front();
      asserts++; if (g.sof !== e.sof) begin fails++; $display("FAIL sof_flag beat %0d: got %b want %b", i, g.sof, e.sof); end
      for (int l = 0; l < 4; l++) begin
        asserts++; if (g.d[l] !== e.d[l]) begin fails++; $display("FAIL sof_data beat %0d lane %0d: got %h want %h", i, l, g.d[l], e.d[l]); end
      end
    end
    exp_q.delete(); got.delete();
  endtask

  task automatic test_reset_midframe();
    beat_t e, g;
    int last;
    for (int c = 0; c < 20; c++) drive_beat(c, W'('h700), c == 0);
    @(posedge clk); #1;
    rst = 1'b0; in_enable = 1'b0; in_sof = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      asserts++;
      if ({o_enable, o_sof, o_overrun} !== 3'b000 || {out0u, out0d, out1u, out1d} !== '0) begin
        fails++; $display("FAIL midreset_outputs: got en=%b sof=%b ovr=%b data=%h want all 0", o_enable, o_sof, o_overrun, {out0u, out0d, out1u, out1d});
      end
    end
    @(posedge clk); #1; rst = 1'b1;
    repeat (6) idle_cycle();
    asserts++; if (got.size() != 0) begin fails++; $display("FAIL midreset_stale: got %0d beats want 0", got.size()); end
    got.delete();
    push_frame(W'('h800));
    drive_frame(W'('h800), 1'b0, last);
    idle_cycle();
    wait_out();
    asserts++; if (got.size() != BEATS) begin fails++; $display("FAIL midreset_count: got %0d want %0d", got.size(), BEATS); end
    for (int i = 0; exp_q.size() > 0 && got.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got.pop_front();
      asserts++; if (g.sof !== e.sof) begin fails++; $display("FAIL midreset_sof beat %0d: got %b want %b", i, g.sof, e.sof); end
      for (int l = 0; l < 4; l++) begin
        asserts++; if (g.d[l] !== e.d[l]) begin fails++; $display("FAIL midreset_data beat %0d lane %0d: got %h want %h", i, l, g.d[l], e.d[l]); end
      end
    end
    exp_q.delete(); got.delete();
  endtask

  task automatic test_overrun();
    int last;
    asserts++; if (o_overrun !== 1'b0) begin fails++; $display("FAIL ovr_initial: got %b want 0", o_overrun); end
    force dut.state = 1'b1;
    force dut.rcnt  = '0;
    drive_frame(W'('h900), 1'b0, last);
    drive_frame(W'('hA00), 1'b0, last);
    idle_cycle();
    @(negedge clk);
    asserts++; if (o_overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", o_overrun); end
    release dut.state;
    release dut.rcnt;
    repeat (80) idle_cycle();
    @(negedge clk);
    asserts++; if (o_overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", o_overrun); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    asserts++; if (o_overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", o_overrun); end
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) idle_cycle();
    got.delete();
  endtask

  initial begin
    for (int l = 0; l < 4; l++) in_l[l] = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_random_enable();
    test_sof_restart();
    test_reset_midframe();
    test_overrun();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
`default_nettype wire
